// File: rtl/dmem_pkg.sv
// Shared constants and load/store formatting helpers for the dmem_lsu_bank data-memory bank.

package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 4;

  typedef struct packed {
    logic        valid;
    logic        we;
    logic        err;
    logic [31:0] data;
  } rsp_t;

  function automatic logic [3:0] lane_mask(logic [2:0] funct3, logic [1:0] off);
    logic [3:0] m;
    case (funct3[1:0])
      2'b00:   m = 4'b0001 << off;
      2'b01:   m = 4'b0011 << off;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] load_extend(logic [2:0] funct3, logic [1:0] off,
                                              logic [31:0] word);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {off, 3'b000};
    case (funct3)
      F3_B:    res = {{24{sh[7]}}, sh[7:0]};
      F3_BU:   res = {24'h0, sh[7:0]};
      F3_H:    res = {{16{sh[15]}}, sh[15:0]};
      F3_HU:   res = {16'h0, sh[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port DEPTH x 32 synchronous RAM with byte write enables and a registered read.

module dmem_ram #(
  parameter int unsigned DEPTH = 4096
) (
  input  logic                     clk,
  input  logic [3:0]               we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) begin
        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_lsu_bank.sv
// RV32 data-memory bank with load/store formatting and configurable read latency.
// Optional DMEM_ZERO_INIT_EN: zero the RAM after reset before accepting requests.

module dmem_lsu_bank
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH  = 4096,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clka,
  input  logic              rsta_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic              rsp_we,
  output logic              rsp_err,
  output logic              [31:0] rsp_rdata
);

  // DEPTH must be at least 2 so the word index slice is non-empty.
  localparam int unsigned IDX_W = $clog2(DEPTH);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
    $error("dmem_lsu_bank: RD_LAT out of range");
  end

  logic             oor, illegal, misal, err, accept;
  logic [1:0]       off;
  logic [IDX_W-1:0] idx;
  logic [31:0]      wrep;
  logic [3:0]       st_we;
  logic             in_init;
  logic [IDX_W-1:0] init_cnt;

  assign off = req_addr[1:0];
  assign idx = req_addr[IDX_W+1:2];

  if (ADDR_W > IDX_W + 2) begin : g_oor
    assign oor = |req_addr[ADDR_W-1:IDX_W+2];
  end else begin : g_no_oor
    assign oor = 1'b0;
  end

  assign illegal = req_we ? (req_funct3 > F3_W)
                          : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
  assign misal   = (req_funct3[1:0] == 2'b01 && off[0]) ||
                   (req_funct3[1:0] == 2'b10 && off != 2'b00);
  assign err     = oor | illegal | misal;
  assign accept  = req_valid & req_ready;

  always_comb begin
    wrep = req_wdata;
    case (req_funct3[1:0])
      2'b00:   wrep = {4{req_wdata[7:0]}};
      2'b01:   wrep = {2{req_wdata[15:0]}};
      default: wrep = req_wdata;
    endcase
  end

  assign st_we = (accept && req_we && !err) ? lane_mask(req_funct3, off) : 4'b0000;

  logic [3:0]       ram_we;
  logic [IDX_W-1:0] ram_addr;
  logic [31:0]      ram_wdata, ram_rdata;

  assign ram_we    = in_init ? 4'b1111  : st_we;
  assign ram_addr  = in_init ? init_cnt : idx;
  assign ram_wdata = in_init ? 32'h0    : wrep;

  dmem_ram #(
    .DEPTH(DEPTH)
  ) u_ram (
    .clk  (clka),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

`ifdef DMEM_ZERO_INIT_EN
  typedef enum logic {StInit, StRun} state_e;
  state_e state_q;
  logic   ready_q;
  logic [IDX_W-1:0] cnt_q;

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      state_q <= StInit;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        StInit: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == IDX_W'(DEPTH - 1)) begin
            state_q <= StRun;
            ready_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_init   = (state_q == StInit);
  assign init_cnt  = cnt_q;
  assign req_ready = ready_q;
`else
  assign in_init   = 1'b0;
  assign init_cnt  = '0;
  assign req_ready = 1'b1;
`endif

  // Sidebands registered in step with the RAM read register.
  logic       s0_valid, s0_we, s0_err;
  logic [2:0] s0_funct3;
  logic [1:0] s0_off;

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      s0_valid  <= 1'b0;
      s0_we     <= 1'b0;
      s0_err    <= 1'b0;
      s0_funct3 <= 3'b000;
      s0_off    <= 2'b00;
    end else begin
      s0_valid  <= accept;
      s0_we     <= req_we;
      s0_err    <= err;
      s0_funct3 <= req_funct3;
      s0_off    <= off;
    end
  end

  rsp_t rsp0, rsp_out;

  always_comb begin
    rsp0       = '0;
    rsp0.valid = s0_valid;
    rsp0.we    = s0_valid & s0_we;
    rsp0.err   = s0_valid & s0_err;
    if (s0_valid && !s0_we && !s0_err) begin
      rsp0.data = load_extend(s0_funct3, s0_off, ram_rdata);
    end
  end

  if (RD_LAT == 1) begin : g_lat1
    assign rsp_out = rsp0;
  end else begin : g_latn
    rsp_t pipe_q [RD_LAT-1];

    always_ff @(posedge clka or negedge rsta_n) begin
      if (!rsta_n) begin
        for (int i = 0; i < RD_LAT - 1; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= rsp0;
        for (int i = 1; i < RD_LAT - 1; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign rsp_out = pipe_q[RD_LAT-2];
  end

  assign rsp_valid = rsp_out.valid;
  assign rsp_we    = rsp_out.we;
  assign rsp_err   = rsp_out.err;
  assign rsp_rdata = rsp_out.data;

endmodule

// File: tb/tb_dmem_lsu_bank.sv
// Bench for dmem_lsu_bank: RD_LAT=1 and RD_LAT=3 instances share stimulus and a byte-array model.

module tb_dmem_lsu_bank;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned BYTES = DEPTH * 4;

  logic        clka = 1'b0;
  logic        rsta_n;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;

  logic        r1_ready, r1_valid, r1_we, r1_err;
  logic [31:0] r1_rdata;
  logic        r3_ready, r3_valid, r3_we, r3_err;
  logic [31:0] r3_rdata;

  always #5 clka = ~clka;

  dmem_lsu_bank #(.DEPTH(DEPTH), .ADDR_W(32), .RD_LAT(1)) dut1 (
    .clka(clka), .rsta_n(rsta_n), .req_valid(req_valid), .req_ready(r1_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(r1_valid), .rsp_we(r1_we), .rsp_err(r1_err), .rsp_rdata(r1_rdata)
  );

  dmem_lsu_bank #(.DEPTH(DEPTH), .ADDR_W(32), .RD_LAT(3)) dut3 (
    .clka(clka), .rsta_n(rsta_n), .req_valid(req_valid), .req_ready(r3_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(r3_valid), .rsp_we(r3_we), .rsp_err(r3_err), .rsp_rdata(r3_rdata)
  );

  typedef struct {
    int          due;
    bit          we;
    bit          err;
    bit [31:0]   data;
    bit          lit;
    bit [31:0]   lit_d;
    bit          lit_e;
  } exp_t;

  exp_t      q1[$];
  exp_t      q3[$];
  logic [7:0] mem_m [BYTES];
  int        cyc = 0;
  int        checks = 0;
  int        errors = 0;
  bit        cur_lit = 0;
  bit [31:0] cur_lit_d = 0;
  bit        cur_lit_e = 0;
  bit        rdy1_s = 0;
  bit        rdy3_s = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference behaviour: byte-addressed memory, size from funct3, arithmetic sign extension.
  function automatic exp_t model_req(bit we, bit [2:0] f3, bit [31:0] a, bit [31:0] wd);
    exp_t        e;
    int unsigned size;
    bit          bad;
    bit [31:0]   v;
    e = '{default: 0};
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    bad = (a >= BYTES);
    if (we) bad = bad | (f3 > 3'd2);
    else    bad = bad | (f3 == 3'd3) | (f3 == 3'd6) | (f3 == 3'd7);
    if ((a % size) != 0) bad = 1;
    e.we  = we;
    e.err = bad;
    if (!bad) begin
      if (we) begin
        for (int b = 0; b < int'(size); b++) mem_m[a + b] = wd[8*b +: 8];
      end else begin
        v = 0;
        for (int b = 0; b < int'(size); b++) v[8*b +: 8] = mem_m[a + b];
        if (!f3[2] && size < 4 && v[8*size-1]) v = v - (32'd1 << (8*size));
        e.data = v;
      end
    end
    return e;
  endfunction

  initial forever begin
    exp_t e;
    @(posedge clka);
    cyc++;
    if (rsta_n && req_valid && (rdy1_s || rdy3_s)) begin
      e = model_req(req_we, req_funct3, req_addr, req_wdata);
      e.lit   = cur_lit;
      e.lit_d = cur_lit_d;
      e.lit_e = cur_lit_e;
      if (rdy1_s) begin e.due = cyc;     q1.push_back(e); end
      if (rdy3_s) begin e.due = cyc + 2; q3.push_back(e); end
    end
  end

  task automatic check_rsp(input string nm, input bit due, input exp_t e, input logic v,
                           input logic we, input logic err, input logic [31:0] d);
    if (due) begin
      chk({nm, "_valid"}, v, 1);
      chk({nm, "_we"}, we, e.we);
      chk({nm, "_err"}, err, e.err);
      chk({nm, "_rdata"}, d, e.data);
      if (e.lit) begin
        chk({nm, "_lit_rdata"}, e.data, e.lit_d);
        chk({nm, "_lit_err"}, e.err, e.lit_e);
      end
    end else begin
      chk({nm, "_idle_valid"}, v, 0);
    end
  endtask

  initial forever begin
    exp_t e1, e3;
    bit   d1, d3;
    @(negedge clka);
    rdy1_s = r1_ready;
    rdy3_s = r3_ready;
    e1 = '{default: 0};
    e3 = '{default: 0};
    d1 = (q1.size() > 0) && (q1[0].due == cyc);
    d3 = (q3.size() > 0) && (q3[0].due == cyc);
    if (d1) e1 = q1.pop_front();
    if (d3) e3 = q3.pop_front();
    check_rsp("lat1", d1, e1, r1_valid, r1_we, r1_err, r1_rdata);
    check_rsp("lat3", d3, e3, r3_valid, r3_we, r3_err, r3_rdata);
    if (!rsta_n) begin
      chk("rst_rsp1", {r1_valid, r1_we, r1_err}, 0);
      chk("rst_rdata1", r1_rdata, 0);
      chk("rst_rsp3", {r3_valid, r3_we, r3_err}, 0);
      chk("rst_rdata3", r3_rdata, 0);
    end
`ifndef DMEM_ZERO_INIT_EN
    if (rsta_n) chk("ready", {r1_ready, r3_ready}, 2'b11);
`endif
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, errors %0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic drive(input bit we, input bit [2:0] f3, input bit [31:0] a,
                       input bit [31:0] wd, input bit lit, input bit [31:0] lit_d,
                       input bit lit_e);
    req_valid  = 1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    cur_lit    = lit;
    cur_lit_d  = lit_d;
    cur_lit_e  = lit_e;
    @(posedge clka); #1;
    req_valid  = 0;
    cur_lit    = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clka); #1; end
  endtask

  // Counts cycles with req_ready low after reset release, bounded.
  task automatic count_init(output int n);
    n = 0;
    for (int i = 0; i < 4 * int'(DEPTH); i++) begin
      @(negedge clka);
      if (r1_ready && r3_ready) return;
      n++;
    end
  endtask

  task automatic do_reset(input int hold);
    int n;
    rsta_n    = 0;
    req_valid = 0;
    q1.delete();
    q3.delete();
    idle(hold);
    rsta_n = 1;
`ifdef DMEM_ZERO_INIT_EN
    for (int i = 0; i < int'(BYTES); i++) mem_m[i] = 8'h00;
    count_init(n);
    chk("reinit_len", n, DEPTH);
    @(posedge clka); #1;
`endif
  endtask

  initial begin
    int        n;
    bit        we;
    bit [2:0]  f3;
    bit [31:0] a;
    rsta_n = 0; req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    for (int i = 0; i < int'(BYTES); i++) mem_m[i] = 8'h00;
    idle(3);
    rsta_n = 1;

`ifdef DMEM_ZERO_INIT_EN
    count_init(n);
    chk("init_len", n, DEPTH);
    @(posedge clka); #1;
    // Reset pulsed halfway through init must restart the full sweep.
    rsta_n = 0;
    idle(2);
    rsta_n = 1;
    idle(DEPTH / 2);
    rsta_n = 0;
    idle(2);
    rsta_n = 1;
    count_init(n);
    chk("init_restart_len", n, DEPTH);
    @(posedge clka); #1;
    drive(0, 3'b010, 32'h0,   0, 1, 32'h0, 0);
    drive(0, 3'b010, 32'h7C,  0, 1, 32'h0, 0);
    drive(0, 3'b000, 32'hFF,  0, 1, 32'h0, 0);
`else
    idle(1);
`endif

    for (int w = 0; w < int'(DEPTH); w++) drive(1, 3'b010, w * 4, $urandom, 0, 0, 0);

    drive(1, 3'b010, 32'h10, 32'hDEADBEEF, 1, 32'h0,        0);
    drive(0, 3'b010, 32'h10, 0,            1, 32'hDEADBEEF, 0);
    drive(0, 3'b000, 32'h13, 0,            1, 32'hFFFFFFDE, 0);
    drive(0, 3'b100, 32'h13, 0,            1, 32'h000000DE, 0);
    drive(0, 3'b001, 32'h12, 0,            1, 32'hFFFFDEAD, 0);
    drive(0, 3'b101, 32'h10, 0,            1, 32'h0000BEEF, 0);
    drive(1, 3'b000, 32'h11, 32'hAAAAAA55, 1, 32'h0,        0);
    drive(0, 3'b010, 32'h10, 0,            1, 32'hDEAD55EF, 0);
    drive(1, 3'b001, 32'h12, 32'h00001234, 1, 32'h0,        0);
    drive(0, 3'b010, 32'h10, 0,            1, 32'h123455EF, 0);
    drive(0, 3'b010, 32'h12, 0,            1, 32'h0,        1);
    drive(1, 3'b001, 32'h11, 32'h0000FFFF, 1, 32'h0,        1);
    drive(0, 3'b011, 32'h10, 0,            1, 32'h0,        1);
    drive(1, 3'b010, BYTES,  32'hCAFEF00D, 1, 32'h0,        1);
    drive(1, 3'b110, 32'h10, 32'h0,        1, 32'h0,        1);
    drive(0, 3'b010, 32'h10, 0,            1, 32'h123455EF, 0);
    drive(0, 3'b010, 32'h0,  0,            0, 0,            0);
    idle(5);

    drive(0, 3'b010, 32'h0, 0, 0, 0, 0);
    drive(0, 3'b010, 32'h4, 0, 0, 0, 0);
    drive(0, 3'b010, 32'h8, 0, 0, 0, 0);
    idle(5);
    drive(0, 3'b010, 32'h0, 0, 0, 0, 0);
    drive(0, 3'b010, 32'h4, 0, 0, 0, 0);
    drive(0, 3'b010, 32'h8, 0, 0, 0, 0);
    do_reset(2);
    idle(5);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        idle(1);
      end else begin
        we = $urandom_range(0, 1);
        if ($urandom_range(0, 9) < 7) f3 = we ? 3'($urandom_range(0, 2))
                                              : ($urandom_range(0, 1) ? 3'($urandom_range(4, 5))
                                                                      : 3'($urandom_range(0, 2)));
        else f3 = 3'($urandom_range(0, 7));
        a = $urandom_range(0, BYTES - 1);
        if ($urandom_range(0, 1) == 1) a = a & ~32'h3;
        if ($urandom_range(0, 9) == 0) a = $urandom | BYTES;
        drive(we, f3, a, $urandom, 0, 0, 0);
      end
    end
    idle(6);
    chk("drained1", q1.size(), 0);
    chk("drained3", q3.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
